multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TRAP_ON_ILLEGAL, default 1; 1 = illegal opcode parks FSM in TRAP, 0 = illegal opcode treated as NOP (back to FETCH).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (reset=0 sampled at posedge resets).
REQ-004 SHALL have port op  input  7  instruction opcode bits [6:0].
REQ-005 SHALL have port funct3  input  3  instruction bits [14:12].
REQ-006 SHALL have port funct7b5  input  1  instruction bit 30.
REQ-007 SHALL have port Zero  input  1  ALU zero flag.
REQ-008 SHALL have port mem_ready  input  1  memory access completes this cycle.
REQ-009 SHALL have ports PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc  output  1 each  datapath enables/select.
REQ-010 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-011 SHALL have port ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 SHALL have ports illegal  output  1 (high in TRAP) and state  output  4 (current state encoding, debug).

Function
REQ-013 SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, TRAP=11; all outputs combinational from state plus inputs noted below.
REQ-014 SHALL, in FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay in FETCH while mem_ready=0, else go to DECODE.
REQ-015 SHALL, in DECODE: ALUSrcA=01, ALUSrcB=01, add; branch by op: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->TRAP (or FETCH if TRAP_ON_ILLEGAL=0).
REQ-016 SHALL, in MEMADR: ALUSrcA=10, ALUSrcB=01, add; op=0000011->MEMREAD, else MEMWRITE.
REQ-017 SHALL, in MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready=1, then MEMWB.
REQ-018 SHALL, in MEMWB: ResultSrc=01, RegWrite=1; next FETCH.
REQ-019 SHALL, in MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 every cycle held; hold until mem_ready=1, then FETCH.
REQ-020 SHALL, in EXECR: ALUSrcA=10, ALUSrcB=00, funct decode; EXECI: ALUSrcA=10, ALUSrcB=01, funct decode; both ->ALUWB.
REQ-021 SHALL, in ALUWB: ResultSrc=00, RegWrite=1; next FETCH.
REQ-022 SHALL, in BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero; next FETCH.
REQ-023 SHALL, in JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB (rd=PC+4).
REQ-024 SHALL, in TRAP: all enables 0, illegal=1; remain until reset.
REQ-025 SHALL decode funct: funct3 000->sub iff op[5]&funct7b5 else add; 010->slt; 110->or; 111->and; other funct3->add.
REQ-026 SHALL drive ImmSrc from op in every state: 0100011->01, 1100011->10, 1101111->11, else 00.
REQ-027 SHALL drive unlisted outputs 0 in each state; selects not listed are 00.

Reset
REQ-028 SHALL, when reset=0 at posedge, enter FETCH regardless of current state (including mid-MEMWRITE and TRAP); MemWrite, RegWrite, PCWrite, IRWrite SHALL be 0 while reset=0.
REQ-029 SHALL leave state undefined-free: state=0, illegal=0 the cycle after reset released.

Verification
REQ-030 lw (op=0000011), mem_ready=1 always -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB, ResultSrc=01.
REQ-031 sw (op=0100011), mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, then state 0.
REQ-032 R-type sub (op=0110011, funct3=000, funct7b5=1) -> EXECR ALUControl=001, then ALUWB RegWrite=1; funct7b5=0 -> ALUControl=000.
REQ-033 beq with Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; both return to FETCH.
REQ-034 op=1111111 -> TRAP, illegal=1, all enables 0 for 10 cycles; reset=0 one cycle -> state=0, illegal=0.
REQ-035 FETCH with mem_ready=0 for 5 cycles -> IRWrite=PCWrite=0, state stays 0; mem_ready=1 -> IRWrite=PCWrite=1, next state 1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: steps each instruction through fetch, decode, execute,
// memory and writeback states, driving datapath enables and mux selects.
module multicycle_controller #(
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_q;
  state_t     state_d;
  logic [2:0] alu_funct;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Subtract only for register-register with funct7b5; immediate adds never subtract.
  always_comb begin
    alu_funct = ALU_ADD;
    unique case (funct3)
      3'b000:  alu_funct = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_funct = ALU_SLT;
      3'b110:  alu_funct = ALU_OR;
      3'b111:  alu_funct = ALU_AND;
      default: alu_funct = ALU_ADD;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (op)
      OP_STORE:  ImmSrc = 2'b01;
      OP_BRANCH: ImmSrc = 2'b10;
      OP_JAL:    ImmSrc = 2'b11;
      default:   ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_funct;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_funct;
      end
      S_ALUWB:    RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        PCWrite    = Zero;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_TRAP:     illegal = 1'b1;
      default: ;
    endcase
    // Architectural side effects must be suppressed for the whole reset cycle.
    if (!reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: expected output vectors are queued
// as each cycle's stimulus is applied and compared once the DUT outputs settle.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  logic [20:0] act;
  logic [20:0] sb_q[$];
  int checks = 0;
  int passed = 0;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .state(state)
  );

  assign act = {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference table of expected outputs for a given (expected) state and inputs.
  function automatic logic [20:0] model(logic [3:0] st, logic [6:0] o, logic [2:0] f3,
                                        logic f7, logic z, logic mr, logic rst);
    logic pcw, irw, rw, mw, adr, ill;
    logic [1:0] rs, sa, sbb, imm;
    logic [2:0] alu, fdec;
    pcw = 0; irw = 0; rw = 0; mw = 0; adr = 0; ill = 0;
    rs = 0; sa = 0; sbb = 0; alu = 0;
    imm  = (o == 7'h23) ? 2'd1 : (o == 7'h63) ? 2'd2 : (o == 7'h6F) ? 2'd3 : 2'd0;
    fdec = (f3 == 3'b010) ? 3'b101 : (f3 == 3'b110) ? 3'b011 : (f3 == 3'b111) ? 3'b010 :
           (f3 == 3'b000 && o[5] && f7) ? 3'b001 : 3'b000;
    case (st)
      4'd0:  begin sbb = 2; rs = 2; irw = mr; pcw = mr; end
      4'd1:  begin sa = 1; sbb = 1; end
      4'd2:  begin sa = 2; sbb = 1; end
      4'd3:  adr = 1;
      4'd4:  begin rs = 1; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin sa = 2; alu = fdec; end
      4'd7:  begin sa = 2; sbb = 1; alu = fdec; end
      4'd8:  rw = 1;
      4'd9:  begin sa = 2; alu = 3'b001; pcw = z; end
      4'd10: begin sa = 1; sbb = 2; pcw = 1; end
      4'd11: ill = 1;
      default: ;
    endcase
    if (!rst) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
    return {st, pcw, irw, rw, mw, adr, rs, sa, sbb, imm, alu, ill};
  endfunction

  task automatic applyStimulus(input logic [3:0] st, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input logic mr, input logic rst);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; mem_ready = mr; reset = rst;
    sb_q.push_back(model(st, o, f3, f7, z, mr, rst));
  endtask

  task automatic test_reset();
    logic [20:0] e;
    logic rs_seq [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'd0, 7'h03, 3'd0, 1'b0, 1'b0, (i < 2), rs_seq[i]);
      #2; e = sb_q.pop_front(); checks++;
      if (act !== e) $display("[TB] FAIL reset[%0d] got=%h exp=%h", i, act, e);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_lw();
    logic [20:0] e;
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(st[i], 7'h03, 3'b010, 1'b0, 1'b0, (i < 5), 1'b1);
      #2; e = sb_q.pop_front(); checks++;
      if (act !== e) $display("[TB] FAIL lw[%0d] got=%h exp=%h", i, act, e);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    logic [20:0] e;
    int mw_cycles = 0;
    logic [3:0] st [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic       mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(st[i], 7'h23, 3'b010, 1'b0, 1'b0, mr[i], 1'b1);
      #2; e = sb_q.pop_front(); checks++;
      if (MemWrite === 1'b1) mw_cycles++;
      if (act !== e) $display("[TB] FAIL sw[%0d] got=%h exp=%h", i, act, e);
      else passed++;
      @(negedge clk);
    end
    checks++;
    if (mw_cycles !== 4) $display("[TB] FAIL sw_memwrite_len got=%0d exp=4", mw_cycles);
    else passed++;
  endtask

  task automatic test_alu_ops();
    logic [20:0] e;
    logic [6:0] ops [7] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h13};
    logic [2:0] f3s [7] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b010, 3'b000, 3'b010};
    logic       f7s [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] st [5];
    for (int k = 0; k < 7; k++) begin
      st = '{4'd0, 4'd1, (ops[k] == 7'h33) ? 4'd6 : 4'd7, 4'd8, 4'd0};
      for (int i = 0; i < 5; i++) begin
        applyStimulus(st[i], ops[k], f3s[k], f7s[k], 1'b0, (i < 4), 1'b1);
        #2; e = sb_q.pop_front(); checks++;
        if (act !== e) $display("[TB] FAIL alu%0d[%0d] got=%h exp=%h", k, i, act, e);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_beq();
    logic [20:0] e;
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd9, 4'd0};
    for (int z = 1; z >= 0; z--) begin
      for (int i = 0; i < 4; i++) begin
        applyStimulus(st[i], 7'h63, 3'b000, 1'b0, z[0], (i < 3), 1'b1);
        #2; e = sb_q.pop_front(); checks++;
        if (act !== e) $display("[TB] FAIL beq_z%0d[%0d] got=%h exp=%h", z, i, act, e);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jal();
    logic [20:0] e;
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    for (int i = 0; i < 5; i++) begin
      applyStimulus(st[i], 7'h6F, 3'b000, 1'b0, 1'b0, (i < 4), 1'b1);
      #2; e = sb_q.pop_front(); checks++;
      if (act !== e) $display("[TB] FAIL jal[%0d] got=%h exp=%h", i, act, e);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_fetch_stall();
    logic [20:0] e;
    logic [3:0] st [11] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(st[i], 7'h03, 3'b010, 1'b0, 1'b0, (i >= 5 && i < 10), 1'b1);
      #2; e = sb_q.pop_front(); checks++;
      if (act !== e) $display("[TB] FAIL stall[%0d] got=%h exp=%h", i, act, e);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_trap();
    logic [20:0] e;
    logic [3:0] st;
    for (int i = 0; i < 15; i++) begin
      st = (i == 0) ? 4'd0 : (i == 1) ? 4'd1 : (i == 14) ? 4'd0 : 4'd11;
      applyStimulus(st, 7'h7F, 3'b000, 1'b1, 1'b1, (i != 14), (i != 13));
      #2; e = sb_q.pop_front(); checks++;
      if (act !== e) $display("[TB] FAIL trap[%0d] got=%h exp=%h", i, act, e);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [20:0] e;
    logic [3:0] st [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(st[i], 7'h23, 3'b010, 1'b0, 1'b0, (i < 3), (i != 4));
      #2; e = sb_q.pop_front(); checks++;
      if (act !== e) $display("[TB] FAIL rst_sw[%0d] got=%h exp=%h", i, act, e);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0; op = 7'h00; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_lw();
    test_sw();
    test_alu_ops();
    test_beq();
    test_jal();
    test_fetch_stall();
    test_trap();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
